// File: rtl/ram8_bist.sv
// March-style built-in self test for an 8 x 16 RAM8: writes P(a), reads it
// back, then repeats with ~P(a), counting mismatches and the first bad word.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start, seed           one-cycle run request and pattern base value
//   mem_out               combinational read data from the RAM8
//   mem_in, mem_address,
//   mem_load              write data, word address and write enable to RAM8
//   busy, done, pass      run in progress / run finished / finished clean
//   error_count           mismatch count, saturating at 15
//   fail_address          address of the first mismatch (0 if none)
module ram8_bist (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] seed,
    input  logic [15:0] mem_out,
    output logic [15:0] mem_in,
    output logic [2:0]  mem_address,
    output logic        mem_load,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  error_count,
    output logic [2:0]  fail_address
);

    typedef enum logic [2:0] {
        IDLE,
        WR0,
        RD0,
        WR1,
        RD1,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  addr;
    logic [2:0]  addr_nx;
    logic [15:0] seed_q;
    logic [15:0] seed_nx;
    logic [3:0]  err_q;
    logic [3:0]  err_nx;
    logic [2:0]  fail_q;
    logic [2:0]  fail_nx;

    logic [15:0] pat;
    logic [15:0] expected;
    logic        inverted;
    logic        reading;
    logic        writing;
    logic        mismatch;

    assign pat      = seed_q + {13'd0, addr};
    assign inverted = (state == WR1) || (state == RD1);
    assign expected = inverted ? ~pat : pat;
    assign reading  = (state == RD0) || (state == RD1);
    assign writing  = (state == WR0) || (state == WR1);
    assign mismatch = reading && (mem_out != expected);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            addr   <= 3'd0;
            seed_q <= 16'd0;
            err_q  <= 4'd0;
            fail_q <= 3'd0;
        end else begin
            state  <= state_nx;
            addr   <= addr_nx;
            seed_q <= seed_nx;
            err_q  <= err_nx;
            fail_q <= fail_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        seed_nx  = seed_q;
        err_nx   = err_q;
        fail_nx  = fail_q;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    seed_nx  = seed;
                    addr_nx  = 3'd0;
                    err_nx   = 4'd0;
                    fail_nx  = 3'd0;
                    state_nx = WR0;
                end
            end
            WR0, RD0, WR1, RD1: begin
                addr_nx = addr + 3'd1;
                if (addr == 3'd7) begin
                    unique case (state)
                        WR0:     state_nx = RD0;
                        RD0:     state_nx = WR1;
                        WR1:     state_nx = RD1;
                        default: state_nx = DONE;
                    endcase
                end
                if (mismatch) begin
                    if (err_q == 4'd0) begin
                        fail_nx = addr;
                    end
                    if (err_q != 4'd15) begin
                        err_nx = err_q + 4'd1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        busy         = writing || reading;
        done         = (state == DONE);
        mem_load     = writing;
        mem_address  = busy ? addr : 3'd0;
        mem_in       = writing ? expected : 16'd0;
        pass         = done && (err_q == 4'd0);
        error_count  = err_q;
        fail_address = fail_q;
    end

endmodule

// File: doc/ram8_bist.md
RAM8_BIST -- requirements
Module: ram8_bist

Interface
REQ-001 The block SHALL use one clock and one reset: reset is synchronous and active-high, and the ports are named clock and reset.
REQ-002 The block SHALL have no parameters; the memory target is fixed at 8 words x 16 bits.
REQ-003 clock  input  1  rising-edge clock shared with the attached RAM8.
REQ-004 reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
REQ-005 start  input  1  one-cycle request to begin a test run.
REQ-006 seed  input  16  pattern base value, latched when start is accepted.
REQ-007 mem_out  input  16  read data from the RAM8 out port (combinational read of the currently addressed word).
REQ-008 mem_in  output  16  write data driven to the RAM8 in port.
REQ-009 mem_address  output  3  word address driven to the RAM8 address port.
REQ-010 mem_load  output  1  write enable to the RAM8 load port; the write occurs at the next rising edge.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  high after a run completes; sticky until the next accepted start or reset.
REQ-013 pass  output  1  equals done AND (error_count == 0).
REQ-014 error_count  output  4  number of mismatches, saturating at 15.
REQ-015 fail_address  output  3  address of the first mismatch in the run; 0 if there was none.

Function
REQ-016 FSM states SHALL be IDLE, WR0, RD0, WR1, RD1, DONE, with a 3-bit word counter addr.
REQ-017 In IDLE or DONE, start=1 at an edge SHALL perform these actions:
- latch seed;
- clear addr, error_count, fail_address and done;
- go to WR0.
REQ-018 start SHALL be ignored in WR0, RD0, WR1 and RD1.
REQ-019 Pattern P(a) SHALL be (seed_latched + a) mod 2^16, with a zero-extended to 16 bits.
REQ-020 WR0 SHALL drive mem_load=1, mem_address=addr and mem_in=P(addr) for 8 cycles, with addr = 0..7.
REQ-021 RD0 SHALL drive mem_load=0 and mem_address=addr; at each edge, mem_out is compared with P(addr), for addr = 0..7.
REQ-022 WR1 and RD1 SHALL behave as WR0 and RD0, but use ~P(addr) (bitwise inverse).
REQ-023 addr SHALL increment every cycle in WR/RD states; the transition to the next state occurs at the edge where addr=7, and addr wraps to 0.
REQ-024 State order SHALL be WR0 -> RD0 -> WR1 -> RD1 -> DONE; busy is high for exactly 32 cycles per run.
REQ-025 On a mismatch, error_count SHALL increment, holding at 15 if already 15.
REQ-026 If error_count was 0 before a mismatch, fail_address SHALL be set to addr.
REQ-027 The compare at the final RD1 edge SHALL be reflected in error_count in the same cycle that done rises.
REQ-028 Outputs mem_in, mem_address, mem_load, busy and done SHALL be Moore functions of the state and addr only; mem_out never affects them combinationally.
REQ-029 Outputs in IDLE and DONE SHALL be: mem_load=0, mem_address=0, mem_in=0.
REQ-030 In DONE, error_count, fail_address and pass SHALL hold their values until the next accepted start or reset.

Reset
REQ-031 When reset=1 at an edge, the next state SHALL be IDLE from any state, including mid-run; reset has priority over start.
REQ-032 After reset, the following outputs SHALL be 0: mem_in, mem_address, mem_load, busy, done, pass, error_count, fail_address.
REQ-033 RAM8 contents are not cleared by reset; a run after reset SHALL rewrite every word before reading it.

Verification
REQ-034 Reset, then idle 5 cycles -> all outputs 0 and mem_load never 1.
REQ-035 Ideal RAM8 model, seed=15, start pulse:
- WR0 drives mem_in=15..22 at addresses 0..7;
- busy stays high for 32 cycles;
- afterwards done=1, pass=1, error_count=0.
REQ-036 RAM8 model with bit0 of word 5 stuck at 0, seed=0:
- RD0 at address 5 reads 0x0004 (mismatch);
- WR1 writes 0xFFFA, which matches on read;
- afterwards error_count=1, fail_address=5, pass=0.
REQ-037 mem_out tied to 0, seed=1 -> 16 mismatches occur, error_count saturates at 15, fail_address=0, pass=0.
REQ-038 seed=0xFFFC -> WR0 data is 0xFFFC, 0xFFFD, 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x0002, 0x0003 (wrap), and the run passes against the ideal model.
REQ-039 Abort and restart checks:
- a start asserted 3 cycles into a run is ignored;
- reset at cycle 10 of a run -> next cycle shows busy=0, mem_load=0, error_count=0;
- a new start then completes a passing run.
